// File: rtl/bp_me_cache_to_cce.sv
// bp_me_cache_to_cce
// Reverse bridge from a bsg_cache packet initiator into the BlackParrot
// memory system. Each accepted packet becomes one uncached read, uncached
// write or AMO command. The matching response is turned back into a single
// dword on the cache-style v/yumi data handshake. Only one request is ever
// in flight.
//
// Packet layout, MSB to LSB: {opcode[5:0], addr, data, mask}.
// Memory message layout, MSB to LSB:
//   {data[cce_block_width_p], way_id, lce_id, size[2:0], addr, msg_type[3:0]}
module bp_me_cache_to_cce #(
    parameter int paddr_width_p     = 40,
    parameter int dword_width_p     = 64,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int src_lce_id_p      = 0,
    localparam int way_id_width_lp        = $clog2(lce_assoc_p),
    localparam int mask_width_lp          = dword_width_p / 8,
    localparam int bsg_cache_pkt_width_lp = 6 + paddr_width_p + dword_width_p + mask_width_lp,
    localparam int cce_mem_hdr_width_lp   = 4 + paddr_width_p + 3 + lce_id_width_p + way_id_width_lp,
    localparam int cce_mem_msg_width_lp   = cce_block_width_p + cce_mem_hdr_width_lp
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [bsg_cache_pkt_width_lp-1:0] cache_pkt_i,
    input  logic                              v_i,
    output logic                              ready_o,
    output logic [dword_width_p-1:0]          data_o,
    output logic                              v_o,
    input  logic                              yumi_i,
    output logic [cce_mem_msg_width_lp-1:0]   mem_cmd_o,
    output logic                              mem_cmd_v_o,
    input  logic                              mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0]   mem_resp_i,
    input  logic                              mem_resp_v_i,
    output logic                              mem_resp_yumi_o,
    output logic                              error_o
);

    // bsg_cache opcodes handled by the bridge
    localparam logic [5:0] OP_LB  = 6'b000000;
    localparam logic [5:0] OP_LH  = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b000010;
    localparam logic [5:0] OP_LD  = 6'b000011;
    localparam logic [5:0] OP_LBU = 6'b000100;
    localparam logic [5:0] OP_LHU = 6'b000101;
    localparam logic [5:0] OP_LWU = 6'b000110;
    localparam logic [5:0] OP_SB  = 6'b001000;
    localparam logic [5:0] OP_SH  = 6'b001001;
    localparam logic [5:0] OP_SW  = 6'b001010;
    localparam logic [5:0] OP_SD  = 6'b001011;
    localparam logic [5:0] OP_LM  = 6'b001100;
    localparam logic [5:0] OP_SM  = 6'b001101;

    // CCE memory message types and sizes
    localparam logic [3:0] MSG_UC_RD    = 4'd2;
    localparam logic [3:0] MSG_UC_WR    = 4'd3;
    localparam logic [3:0] MSG_AMO_SWAP = 4'd5;
    localparam logic [2:0] SIZE_1 = 3'd0;
    localparam logic [2:0] SIZE_2 = 3'd1;
    localparam logic [2:0] SIZE_4 = 3'd2;
    localparam logic [2:0] SIZE_8 = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        SEND_CMD,
        WAIT_RESP,
        SEND_DATA
    } state_e;

    state_e                     state_q, state_d;
    logic [5:0]                 op_q, op_d;
    logic [paddr_width_p-1:0]   addr_q, addr_d;
    logic [dword_width_p-1:0]   wdata_q, wdata_d;
    logic [3:0]                 type_q, type_d;
    logic [2:0]                 size_q, size_d;
    logic [dword_width_p-1:0]   rdata_q, rdata_d;
    logic                       error_q, error_d;

    logic [5:0]                 pkt_op;
    logic [paddr_width_p-1:0]   pkt_addr;
    logic [dword_width_p-1:0]   pkt_data;
    logic [mask_width_lp-1:0]   pkt_mask;

    logic [3:0]                 dec_type;
    logic [2:0]                 dec_size;
    logic                       dec_legal;

    logic [3:0]                 resp_type;
    logic [paddr_width_p-1:0]   resp_addr;
    logic [dword_width_p-1:0]   resp_dword;
    logic [dword_width_p-1:0]   resp_ext;
    logic                       unused_resp_bits;

    assign pkt_mask = cache_pkt_i[mask_width_lp-1:0];
    assign pkt_data = cache_pkt_i[mask_width_lp +: dword_width_p];
    assign pkt_addr = cache_pkt_i[mask_width_lp + dword_width_p +: paddr_width_p];
    assign pkt_op   = cache_pkt_i[bsg_cache_pkt_width_lp-1 -: 6];

    assign resp_type  = mem_resp_i[3:0];
    assign resp_addr  = mem_resp_i[4 +: paddr_width_p];
    assign resp_dword = mem_resp_i[cce_mem_hdr_width_lp +: dword_width_p];
    assign unused_resp_bits = ^{mem_resp_i[cce_mem_msg_width_lp-1:cce_mem_hdr_width_lp+dword_width_p],
                                mem_resp_i[cce_mem_hdr_width_lp-1:4+paddr_width_p]};

    // Command is built purely from registered fields so it stays stable while stalled
    assign mem_cmd_o = {{(cce_block_width_p-dword_width_p){1'b0}}, wdata_q,
                        {way_id_width_lp{1'b0}}, lce_id_width_p'(src_lce_id_p),
                        size_q, addr_q, type_q};
    assign data_o  = rdata_q;
    assign error_o = error_q;

    // Translate the incoming opcode into a memory message type and size
    always_comb begin
        dec_type  = MSG_UC_RD;
        dec_size  = SIZE_1;
        dec_legal = 1'b1;
        case (pkt_op)
            OP_LB, OP_LBU: dec_size = SIZE_1;
            OP_LH, OP_LHU: dec_size = SIZE_2;
            OP_LW, OP_LWU: dec_size = SIZE_4;
            OP_LD, OP_LM:  dec_size = SIZE_8;
            OP_SB: begin dec_type = MSG_UC_WR; dec_size = SIZE_1; end
            OP_SH: begin dec_type = MSG_UC_WR; dec_size = SIZE_2; end
            OP_SW: begin dec_type = MSG_UC_WR; dec_size = SIZE_4; end
            OP_SD, OP_SM: begin dec_type = MSG_UC_WR; dec_size = SIZE_8; end
            default: begin
                // AMOs occupy 10_xxxx (word) and 11_xxxx (dword), nine functions each
                if (pkt_op[5] && (pkt_op[3:0] <= 4'd8)) begin
                    dec_type = MSG_AMO_SWAP + pkt_op[3:0];
                    dec_size = pkt_op[4] ? SIZE_8 : SIZE_4;
                end else begin
                    dec_legal = 1'b0;
                end
            end
        endcase
    end

    // Right-aligned response data extended according to the outstanding opcode
    always_comb begin
        resp_ext = resp_dword;
        case (op_q)
            OP_LB:  resp_ext = {{(dword_width_p-8){resp_dword[7]}}, resp_dword[7:0]};
            OP_LBU: resp_ext = {{(dword_width_p-8){1'b0}}, resp_dword[7:0]};
            OP_LH:  resp_ext = {{(dword_width_p-16){resp_dword[15]}}, resp_dword[15:0]};
            OP_LHU: resp_ext = {{(dword_width_p-16){1'b0}}, resp_dword[15:0]};
            OP_LW:  resp_ext = {{(dword_width_p-32){resp_dword[31]}}, resp_dword[31:0]};
            OP_LWU: resp_ext = {{(dword_width_p-32){1'b0}}, resp_dword[31:0]};
            OP_SB, OP_SH, OP_SW, OP_SD, OP_SM: resp_ext = '0;
            default: begin
                if (op_q[5] && !op_q[4]) begin
                    resp_ext = {{(dword_width_p-32){resp_dword[31]}}, resp_dword[31:0]};
                end
            end
        endcase
    end

    // Next-state and handshake logic for the single outstanding request
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        type_d          = type_q;
        size_d          = size_q;
        rdata_d         = rdata_q;
        error_d         = error_q;
        ready_o         = 1'b0;
        v_o             = 1'b0;
        mem_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    op_d    = pkt_op;
                    addr_d  = pkt_addr;
                    wdata_d = pkt_data;
                    type_d  = dec_type;
                    size_d  = dec_size;
                    if (dec_legal) begin
                        state_d = SEND_CMD;
                        if ((pkt_op == OP_SM) && !(&pkt_mask)) begin
                            error_d = 1'b1;
                        end
                    end else begin
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = SEND_DATA;
                    end
                end
            end
            SEND_CMD: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_i) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    rdata_d = resp_ext;
                    if ((resp_type != type_q) || (resp_addr != addr_q)) begin
                        error_d = 1'b1;
                    end
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_bp_me_cache_to_cce.sv
// tb_bp_me_cache_to_cce
// Directed bench: the bench plays both the packet initiator and the memory,
// with every expected value written out by hand.
module tb_bp_me_cache_to_cce;

    localparam int PktW = 118;
    localparam int MsgW = 566;
    localparam int HdrW = 54;

    localparam logic [5:0] OP_LB       = 6'b000000;
    localparam logic [5:0] OP_LW       = 6'b000010;
    localparam logic [5:0] OP_LD       = 6'b000011;
    localparam logic [5:0] OP_LBU      = 6'b000100;
    localparam logic [5:0] OP_LHU      = 6'b000101;
    localparam logic [5:0] OP_SD       = 6'b001011;
    localparam logic [5:0] OP_SM       = 6'b001101;
    localparam logic [5:0] OP_TAGST    = 6'b010000;
    localparam logic [5:0] OP_AMOADD_W = 6'b100001;

    logic            clk = 1'b0;
    logic            resetI = 1'b1;
    logic [PktW-1:0] cachePkt = '0;
    logic            vI = 1'b0;
    logic            readyO;
    logic [63:0]     dataO;
    logic            vO;
    logic            yumiI = 1'b0;
    logic [MsgW-1:0] memCmd;
    logic            memCmdV;
    logic            memCmdReady = 1'b0;
    logic [MsgW-1:0] memResp = '0;
    logic            memRespV = 1'b0;
    logic            memRespYumi;
    logic            errorO;

    int checks = 0;
    int errors = 0;

    bp_me_cache_to_cce dut (
        .clk_i           (clk),
        .reset_i         (resetI),
        .cache_pkt_i     (cachePkt),
        .v_i             (vI),
        .ready_o         (readyO),
        .data_o          (dataO),
        .v_o             (vO),
        .yumi_i          (yumiI),
        .mem_cmd_o       (memCmd),
        .mem_cmd_v_o     (memCmdV),
        .mem_cmd_ready_i (memCmdReady),
        .mem_resp_i      (memResp),
        .mem_resp_v_i    (memRespV),
        .mem_resp_yumi_o (memRespYumi),
        .error_o         (errorO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [MsgW-1:0] mkMsg(input logic [3:0] msgType, input logic [2:0] size,
                                              input logic [39:0] addr, input logic [63:0] dataLow);
        return {448'b0, dataLow, 3'b0, 4'b0, size, addr, msgType};
    endfunction

    // Present one packet in IDLE and let it be accepted on the next edge
    task automatic applyStimulus(input logic [5:0] op, input logic [39:0] addr,
                                 input logic [63:0] data, input logic [7:0] mask);
        checkOutput("readyIdle", {63'b0, readyO}, 64'd1);
        cachePkt = {op, addr, data, mask};
        vI = 1'b1;
        #1;
        checkOutput("noCombCmd", {63'b0, memCmdV}, 64'd0);
        step();
        vI = 1'b0;
    endtask

    // Wait for the command, check its fields, stall it, then accept it
    task automatic serveCmd(input string tag, input logic [3:0] expType, input logic [2:0] expSize,
                            input logic [39:0] expAddr, input logic [63:0] expData, input int stall);
        logic [MsgW-1:0] snap;
        for (int i = 0; i < 10 && !memCmdV; i++) step();
        checkOutput({tag, ".cmdV"}, {63'b0, memCmdV}, 64'd1);
        checkOutput({tag, ".type"}, {60'b0, memCmd[3:0]}, {60'b0, expType});
        checkOutput({tag, ".size"}, {61'b0, memCmd[46:44]}, {61'b0, expSize});
        checkOutput({tag, ".addr"}, {24'b0, memCmd[43:4]}, {24'b0, expAddr});
        checkOutput({tag, ".lceWay"}, {57'b0, memCmd[53:47]}, 64'd0);
        checkOutput({tag, ".dataLow"}, memCmd[117:54], expData);
        checkOutput({tag, ".dataHigh"}, {63'b0, |memCmd[MsgW-1:118]}, 64'd0);
        checkOutput({tag, ".readyBusy"}, {63'b0, readyO}, 64'd0);
        snap = memCmd;
        for (int i = 0; i < stall; i++) begin
            step();
            checkOutput({tag, ".cmdStable"}, {63'b0, (memCmd === snap) && memCmdV}, 64'd1);
        end
        memCmdReady = 1'b1;
        step();
        memCmdReady = 1'b0;
        checkOutput({tag, ".cmdDone"}, {63'b0, memCmdV}, 64'd0);
    endtask

    // Return one response and confirm it is consumed in the same cycle
    task automatic sendResp(input string tag, input logic [MsgW-1:0] msg);
        memResp = msg;
        memRespV = 1'b1;
        #1;
        checkOutput({tag, ".respYumi"}, {63'b0, memRespYumi}, 64'd1);
        step();
        memRespV = 1'b0;
        memResp = '0;
    endtask

    // Wait for load data, hold it across a stall, then take it
    task automatic collectData(input string tag, input logic [63:0] expData);
        for (int i = 0; i < 10 && !vO; i++) step();
        checkOutput({tag, ".vO"}, {63'b0, vO}, 64'd1);
        checkOutput({tag, ".data"}, dataO, expData);
        checkOutput({tag, ".readyBusy2"}, {63'b0, readyO}, 64'd0);
        checkOutput({tag, ".noCmd"}, {63'b0, memCmdV}, 64'd0);
        memRespV = 1'b1;
        #1;
        checkOutput({tag, ".strayResp"}, {63'b0, memRespYumi}, 64'd0);
        memRespV = 1'b0;
        step();
        checkOutput({tag, ".vHeld"}, {63'b0, vO}, 64'd1);
        checkOutput({tag, ".dataHeld"}, dataO, expData);
        yumiI = 1'b1;
        step();
        yumiI = 1'b0;
        checkOutput({tag, ".vDone"}, {63'b0, vO}, 64'd0);
        checkOutput({tag, ".readyBack"}, {63'b0, readyO}, 64'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ready"}, {63'b0, readyO}, 64'd1);
        checkOutput({tag, ".vO"}, {63'b0, vO}, 64'd0);
        checkOutput({tag, ".cmdV"}, {63'b0, memCmdV}, 64'd0);
        checkOutput({tag, ".yumi"}, {63'b0, memRespYumi}, 64'd0);
        checkOutput({tag, ".error"}, {63'b0, errorO}, 64'd0);
        checkOutput({tag, ".data"}, dataO, 64'd0);
    endtask

    initial begin
        step(); step(); step();
        resetI = 1'b0;
        checkResetState("reset");

        // LW sign-extends the low word
        applyStimulus(OP_LW, 40'h00_8000_0004, 64'h0, 8'h00);
        serveCmd("lw", 4'd2, 3'd2, 40'h00_8000_0004, 64'h0, 0);
        sendResp("lw", mkMsg(4'd2, 3'd2, 40'h00_8000_0004, 64'hDEAD_BEEF_FFFF_FF80));
        collectData("lw", 64'hFFFF_FFFF_FFFF_FF80);

        // LBU zero-extends, LB sign-extends
        applyStimulus(OP_LBU, 40'h00_8000_0001, 64'h0, 8'h00);
        serveCmd("lbu", 4'd2, 3'd0, 40'h00_8000_0001, 64'h0, 0);
        sendResp("lbu", mkMsg(4'd2, 3'd0, 40'h00_8000_0001, 64'hAAAA_AAAA_AAAA_AA80));
        collectData("lbu", 64'h0000_0000_0000_0080);

        applyStimulus(OP_LB, 40'h00_8000_0001, 64'h0, 8'h00);
        serveCmd("lb", 4'd2, 3'd0, 40'h00_8000_0001, 64'h0, 0);
        sendResp("lb", mkMsg(4'd2, 3'd0, 40'h00_8000_0001, 64'hAAAA_AAAA_AAAA_AA80));
        collectData("lb", 64'hFFFF_FFFF_FFFF_FF80);

        // SD with memory stalled for five cycles; stores return zero
        applyStimulus(OP_SD, 40'h00_8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
        serveCmd("sd", 4'd3, 3'd3, 40'h00_8000_0010, 64'h1122_3344_5566_7788, 5);
        sendResp("sd", mkMsg(4'd3, 3'd3, 40'h00_8000_0010, 64'hFFFF_FFFF_FFFF_FFFF));
        collectData("sd", 64'h0);

        // AMOADD_W returns the sign-extended old word
        applyStimulus(OP_AMOADD_W, 40'h00_8000_0020, 64'h1, 8'h0F);
        serveCmd("amoadd", 4'd6, 3'd2, 40'h00_8000_0020, 64'h1, 0);
        sendResp("amoadd", mkMsg(4'd6, 3'd2, 40'h00_8000_0020, 64'hFFFF_FFFF_7FFF_FFFF));
        collectData("amoadd", 64'h0000_0000_7FFF_FFFF);
        checkOutput("noErrorYet", {63'b0, errorO}, 64'd0);

        // TAGST never reaches memory, returns zero and sets the sticky error
        applyStimulus(OP_TAGST, 40'h00_8000_0040, 64'h5, 8'hFF);
        checkOutput("tagst.noCmd", {63'b0, memCmdV}, 64'd0);
        checkOutput("tagst.error", {63'b0, errorO}, 64'd1);
        collectData("tagst", 64'h0);

        // A later legal request leaves the error set
        applyStimulus(OP_LHU, 40'h00_8000_0002, 64'h0, 8'h00);
        serveCmd("lhu", 4'd2, 3'd1, 40'h00_8000_0002, 64'h0, 0);
        sendResp("lhu", mkMsg(4'd2, 3'd1, 40'h00_8000_0002, 64'h1234_5678_9ABC_8001));
        collectData("lhu", 64'h0000_0000_0000_8001);
        checkOutput("errorSticky", {63'b0, errorO}, 64'd1);

        // Reset while waiting for a response, then a clean LD
        applyStimulus(OP_LW, 40'h00_8000_0008, 64'h0, 8'h00);
        serveCmd("lwAbort", 4'd2, 3'd2, 40'h00_8000_0008, 64'h0, 0);
        resetI = 1'b1;
        step();
        resetI = 1'b0;
        checkResetState("midReset");
        memRespV = 1'b1;
        #1;
        checkOutput("idleRespIgnored", {63'b0, memRespYumi}, 64'd0);
        memRespV = 1'b0;
        applyStimulus(OP_LD, 40'h00_8000_0018, 64'h0, 8'h00);
        serveCmd("ld", 4'd2, 3'd3, 40'h00_8000_0018, 64'h0, 1);
        sendResp("ld", mkMsg(4'd2, 3'd3, 40'h00_8000_0018, 64'h0123_4567_89AB_CDEF));
        collectData("ld", 64'h0123_4567_89AB_CDEF);
        checkOutput("ld.error", {63'b0, errorO}, 64'd0);

        // Response whose type disagrees with the command: data returned, error set
        applyStimulus(OP_LD, 40'h00_8000_0040, 64'h0, 8'h00);
        serveCmd("ldBad", 4'd2, 3'd3, 40'h00_8000_0040, 64'h0, 0);
        sendResp("ldBad", mkMsg(4'd3, 3'd3, 40'h00_8000_0040, 64'hCAFE_F00D_0000_0001));
        checkOutput("ldBad.error", {63'b0, errorO}, 64'd1);
        collectData("ldBad", 64'hCAFE_F00D_0000_0001);

        // Partial-mask SM still writes a full dword but flags an error
        resetI = 1'b1;
        step();
        resetI = 1'b0;
        checkOutput("smPre.error", {63'b0, errorO}, 64'd0);
        applyStimulus(OP_SM, 40'h00_8000_0048, 64'h0000_0000_0000_CAFE, 8'h0F);
        checkOutput("sm.error", {63'b0, errorO}, 64'd1);
        serveCmd("sm", 4'd3, 3'd3, 40'h00_8000_0048, 64'h0000_0000_0000_CAFE, 0);
        sendResp("sm", mkMsg(4'd3, 3'd3, 40'h00_8000_0048, 64'h0));
        collectData("sm", 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
